// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared defaults, state encoding and channel-index helper for
//               the PWM fade scheduler and its command/write interface.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

  // Default bank geometry: 8 channels of 8-bit period values.
  localparam int NCH_DEF = 8;
  localparam int DW_DEF  = 8;

  // Channel-index width; a single-channel bank still needs a 1-bit index.
  function automatic int ch_iw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int CH_IW = ch_iw(NCH_DEF);

  // Scheduler control states.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_fade_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_fade_scheduler_if
// Description : Command port (valid/ready) plus the period-register write
//               port towards the PWM bank and the scan-busy flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_fade_scheduler_if
  import pwm_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int DW  = DW_DEF
) ();

  localparam int IW = ch_iw(NCH);

  // Command side
  logic          CMD_VALID;
  logic          CMD_READY;
  logic [IW-1:0] CMD_ADDR;
  logic [DW-1:0] CMD_DATA;
  logic          CMD_IMM;

  // PWM bank write side
  logic          PER_WE;
  logic [IW-1:0] PER_ADDR;
  logic [DW-1:0] PER_DATA;
  logic          BUSY;

  // Host / command source view
  modport master (
    output CMD_VALID, CMD_ADDR, CMD_DATA, CMD_IMM,
    input  CMD_READY, PER_WE, PER_ADDR, PER_DATA, BUSY
  );

  // Scheduler view
  modport slave (
    input  CMD_VALID, CMD_ADDR, CMD_DATA, CMD_IMM,
    output CMD_READY, PER_WE, PER_ADDR, PER_DATA, BUSY
  );

endinterface
`default_nettype wire

// File: rtl/pwm_tick_div.sv
`default_nettype none
// ============================================================================
// Module      : pwm_tick_div
// Description : Free-running 16-bit prescaler; emits a one-cycle tick every
//               DIV clock cycles (when the count sits at DIV-1).
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_tick_div #(
  parameter int DIV = 1000
) (
  input  wire logic clk,
  input  wire logic rst,
  output logic      o_tick
);

  localparam logic [15:0] c_last = 16'(DIV - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Next count: wrap to zero after the last value of the period.
  always_comb begin
    cnt_d = (cnt_q == c_last) ? 16'd0 : cnt_q + 16'd1;
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tick = (cnt_q == c_last);

endmodule
`default_nettype wire

// File: rtl/pwm_fade_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pwm_fade_scheduler
// Description : Holds current/target values for a bank of PWM channels.
//               Commands set targets (fade) or jump immediately; on every
//               prescaler tick all channels are scanned round-robin and each
//               current value steps one count toward its target, producing
//               period-register writes to the PWM bank.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_fade_scheduler
  import pwm_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int DW  = DW_DEF,
  parameter int DIV = 1000
) (
  input  wire logic           CLK_100MHz,
  input  wire logic           RST,
  pwm_fade_scheduler_if.slave bus
);

  localparam int            IW        = ch_iw(NCH);
  localparam logic [IW-1:0] c_last_ch = IW'(NCH - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] cur_q [NCH];
  logic [DW-1:0] cur_d [NCH];
  logic [DW-1:0] tgt_q [NCH];
  logic [DW-1:0] tgt_d [NCH];

  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          per_we_q, per_we_d;
  logic [IW-1:0] per_addr_q, per_addr_d;
  logic [DW-1:0] per_data_q, per_data_d;

  logic          w_tick;
  logic          w_accept;
  logic [DW-1:0] w_scan_cur;
  logic [DW-1:0] w_scan_tgt;
  logic [DW-1:0] w_scan_next;

  pwm_tick_div #(
    .DIV (DIV)
  ) u_tick_div (
    .clk    (CLK_100MHz),
    .rst    (RST),
    .o_tick (w_tick)
  );

  // ready_q is only ever high while the FSM sits in IDLE (and not in the
  // first cycle after reset), so it alone qualifies a command handshake.
  assign w_accept = bus.CMD_VALID && ready_q;

  // One-count step of the channel under scan toward its target, saturating
  // exactly at the target so neither end of the range can wrap.
  always_comb begin
    w_scan_cur = cur_q[idx_q];
    w_scan_tgt = tgt_q[idx_q];
    if (w_scan_cur < w_scan_tgt) begin
      w_scan_next = w_scan_cur + DW'(1);
    end else if (w_scan_cur > w_scan_tgt) begin
      w_scan_next = w_scan_cur - DW'(1);
    end else begin
      w_scan_next = w_scan_cur;
    end
  end

  // Next-state, channel storage updates and registered output values.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cur_d      = cur_q;
    tgt_d      = tgt_q;
    per_we_d   = 1'b0;
    per_addr_d = per_addr_q;
    per_data_d = per_data_q;

    case (state_q)
      IDLE: begin
        // A command accepted together with a tick lands first; the scan
        // starting next cycle then sees the updated cur/tgt.
        if (w_accept) begin
          tgt_d[bus.CMD_ADDR] = bus.CMD_DATA;
          if (bus.CMD_IMM) begin
            cur_d[bus.CMD_ADDR] = bus.CMD_DATA;
            per_we_d            = 1'b1;
            per_addr_d          = bus.CMD_ADDR;
            per_data_d          = bus.CMD_DATA;
          end
        end
        if (w_tick) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end

      SCAN: begin
        if (w_scan_next != w_scan_cur) begin
          cur_d[idx_q] = w_scan_next;
          per_we_d     = 1'b1;
          per_addr_d   = idx_q;
          per_data_d   = w_scan_next;
        end
        idx_d = idx_q + IW'(1);
        if (idx_q == c_last_ch) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake and busy flags follow the state being entered so that they
    // line up with the registered state on the next cycle.
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == SCAN);
  end

  // Control and output registers.
  always_ff @(posedge CLK_100MHz or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      per_we_q   <= 1'b0;
      per_addr_q <= '0;
      per_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      per_we_q   <= per_we_d;
      per_addr_q <= per_addr_d;
      per_data_q <= per_data_d;
    end
  end

  // Per-channel current and target storage.
  always_ff @(posedge CLK_100MHz or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NCH; i++) begin
        cur_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else begin
      cur_q <= cur_d;
      tgt_q <= tgt_d;
    end
  end

  assign bus.CMD_READY = ready_q;
  assign bus.BUSY      = busy_q;
  assign bus.PER_WE    = per_we_q;
  assign bus.PER_ADDR  = per_addr_q;
  assign bus.PER_DATA  = per_data_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_fade_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_fade_scheduler
// Description : Self-checking bench for pwm_fade_scheduler (NCH=8, DW=8,
//               DIV=10) with a cycle-indexed reference model, a directed
//               command table, hand-written corner sequences and random
//               command traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_fade_scheduler;

  localparam int NCH = 8;
  localparam int DW  = 8;
  localparam int DIV = 10;

  logic clk;
  logic rst;

  pwm_fade_scheduler_if #(.NCH(NCH), .DW(DW)) bus ();

  pwm_fade_scheduler #(.NCH(NCH), .DW(DW), .DIV(DIV)) dut (
    .CLK_100MHz (clk),
    .RST        (rst),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int a;
    int d;
  } wr_t;

  typedef struct {
    bit imm;
    int addr;
    int data;
    bit exp_we;
    int exp_addr;
    int exp_data;
  } vec_t;

  // Reference model state. Interval n is the time after the n-th rising edge
  // following reset release (n = -1 before the first edge). The prescaler
  // holds (n+1) mod DIV in interval n, so a tick occurs when that equals
  // DIV-1; a tick in interval k scans channel j in interval k+1+j.
  int  m_cur [NCH];
  int  m_tgt [NCH];
  wr_t wq[$];
  wr_t seen[$];
  int  cyc;
  int  last_tick;
  int  n_cmp;
  int  n_fail;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (interval %0d)", name, act, req, cyc);
    end
  endtask

  task automatic bound_expired(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired (interval %0d)", name, cyc);
  endtask

  function automatic bit in_scan();
    return (cyc > last_tick) && (cyc <= last_tick + NCH);
  endfunction

  function automatic bit tick_now();
    return ((cyc + 1) % DIV) == (DIV - 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cur[i] = 0;
      m_tgt[i] = 0;
    end
    wq.delete();
    last_tick = -1000;
    cyc       = -1;
  endtask

  // Compare the DUT against the model for the current interval, then advance
  // the model across the coming rising edge using the inputs now applied.
  task automatic model_step();
    bit  e_busy;
    bit  e_ready;
    bit  e_we;
    int  e_a;
    int  e_d;
    int  j;
    int  nv;
    wr_t w;
    e_busy  = in_scan();
    e_ready = (cyc >= 0) && !e_busy;
    e_we    = 1'b0;
    e_a     = 0;
    e_d     = 0;
    if (wq.size() > 0 && wq[0].cyc == cyc) begin
      e_we = 1'b1;
      e_a  = wq[0].a;
      e_d  = wq[0].d;
      void'(wq.pop_front());
    end
    chk("cmd_ready", int'(bus.CMD_READY), int'(e_ready));
    chk("busy", int'(bus.BUSY), int'(e_busy));
    chk("per_we", int'(bus.PER_WE), int'(e_we));
    if (e_we) begin
      chk("per_addr", int'(bus.PER_ADDR), e_a);
      chk("per_data", int'(bus.PER_DATA), e_d);
    end
    if (bus.PER_WE === 1'b1) begin
      w.cyc = cyc;
      w.a   = int'(bus.PER_ADDR);
      w.d   = int'(bus.PER_DATA);
      seen.push_back(w);
    end
    if (bus.CMD_VALID && e_ready) begin
      m_tgt[int'(bus.CMD_ADDR)] = int'(bus.CMD_DATA);
      if (bus.CMD_IMM) begin
        m_cur[int'(bus.CMD_ADDR)] = int'(bus.CMD_DATA);
        w.cyc = cyc + 1;
        w.a   = int'(bus.CMD_ADDR);
        w.d   = int'(bus.CMD_DATA);
        wq.push_back(w);
      end
    end
    if (e_busy) begin
      j  = cyc - last_tick - 1;
      nv = m_cur[j];
      if (nv < m_tgt[j]) nv = nv + 1;
      else if (nv > m_tgt[j]) nv = nv - 1;
      if (nv != m_cur[j]) begin
        m_cur[j] = nv;
        w.cyc = cyc + 1;
        w.a   = j;
        w.d   = nv;
        wq.push_back(w);
      end
    end
    if (tick_now() && !e_busy) last_tick = cyc;
  endtask

  task automatic run_cycle();
    model_step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  // Advance to an idle interval that is not a tick interval.
  task automatic wait_quiet();
    int g;
    g = 0;
    while (!((cyc >= 0) && !in_scan() && !tick_now())) begin
      run_cycle();
      g++;
      if (g > 4 * DIV) begin
        bound_expired("wait_quiet");
        return;
      end
    end
  endtask

  task automatic wait_tick();
    int g;
    g = 0;
    while (!tick_now()) begin
      run_cycle();
      g++;
      if (g > 4 * DIV) begin
        bound_expired("wait_tick");
        return;
      end
    end
  endtask

  task automatic drive(input bit v, input bit imm, input int a, input int d);
    bus.CMD_VALID = v;
    bus.CMD_IMM   = imm;
    bus.CMD_ADDR  = 3'(a);
    bus.CMD_DATA  = 8'(d);
  endtask

  // Issue one command in a quiet interval; returns in the following interval.
  task automatic send(input bit imm, input int a, input int d);
    wait_quiet();
    drive(1'b1, imm, a, d);
    run_cycle();
    drive(1'b0, 1'b0, 0, 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_per_we"}, int'(bus.PER_WE), 0);
    chk({tag, "_per_addr"}, int'(bus.PER_ADDR), 0);
    chk({tag, "_per_data"}, int'(bus.PER_DATA), 0);
    chk({tag, "_busy"}, int'(bus.BUSY), 0);
    chk({tag, "_cmd_ready"}, int'(bus.CMD_READY), 0);
  endtask

  vec_t vecs[8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    int low;
    int r;

    n_cmp  = 0;
    n_fail = 0;

    vecs[0] = '{1'b1, 0, 8'h00, 1'b1, 0, 8'h00};
    vecs[1] = '{1'b1, 7, 8'hFF, 1'b1, 7, 8'hFF};
    vecs[2] = '{1'b0, 4, 8'h33, 1'b0, 0, 0};
    vecs[3] = '{1'b1, 4, 8'h33, 1'b1, 4, 8'h33};
    vecs[4] = '{1'b1, 1, 8'h01, 1'b1, 1, 8'h01};
    vecs[5] = '{1'b0, 6, 8'hAA, 1'b0, 0, 0};
    vecs[6] = '{1'b1, 2, 8'h7F, 1'b1, 2, 8'h7F};
    vecs[7] = '{1'b1, 5, 8'h80, 1'b1, 5, 8'h80};

    // ---------------- reset state ----------------
    rst = 1'b1;
    drive(1'b0, 1'b0, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;
    model_reset();

    // ---------------- immediate write, no rewrite at tick ----------------
    send(1'b1, 3, 8'h80);
    chk("imm_we", int'(bus.PER_WE), 1);
    chk("imm_addr", int'(bus.PER_ADDR), 3);
    chk("imm_data", int'(bus.PER_DATA), 8'h80);
    run_cycle();
    seen.delete();
    run_n(2 * DIV);
    chk("imm_no_rewrite", seen.size(), 0);

    // ---------------- fade up ch2: 0 -> 4 ----------------
    send(1'b0, 2, 8'h04);
    chk("fadeup_no_imm_we", int'(bus.PER_WE), 0);
    run_cycle();
    seen.delete();
    run_n(6 * DIV);
    chk("fadeup_count", seen.size(), 4);
    for (int k = 0; k < seen.size() && k < 4; k++) begin
      chk("fadeup_addr", seen[k].a, 2);
      chk("fadeup_data", seen[k].d, k + 1);
      chk("fadeup_slot", (seen[k].cyc - 3) % DIV, DIV - 1);
    end

    // ---------------- fade down ch5: 0xFF -> 0xFD ----------------
    send(1'b1, 5, 8'hFF);
    send(1'b0, 5, 8'hFD);
    run_cycle();
    seen.delete();
    run_n(5 * DIV);
    chk("fadedown_count", seen.size(), 2);
    if (seen.size() >= 2) begin
      chk("fadedown_addr0", seen[0].a, 5);
      chk("fadedown_data0", seen[0].d, 8'hFE);
      chk("fadedown_addr1", seen[1].a, 5);
      chk("fadedown_data1", seen[1].d, 8'hFD);
    end

    // ---------------- tick coincides with accepted command ----------------
    wait_tick();
    run_n(DIV - 1);
    drive(1'b1, 1'b1, 0, 8'h10);   // interval before the tick
    run_cycle();
    drive(1'b1, 1'b0, 0, 8'h12);   // accepted in the tick interval
    run_cycle();
    drive(1'b0, 1'b0, 0, 0);
    chk("coinc_fade_no_we", int'(bus.PER_WE), 0);
    run_cycle();
    chk("coinc_scan_we", int'(bus.PER_WE), 1);
    chk("coinc_scan_addr", int'(bus.PER_ADDR), 0);
    chk("coinc_scan_data", int'(bus.PER_DATA), 8'h11);

    wait_tick();
    drive(1'b1, 1'b1, 0, 8'h40);   // immediate in the tick interval
    run_cycle();
    drive(1'b0, 1'b0, 0, 0);
    chk("coinc_imm_we", int'(bus.PER_WE), 1);
    chk("coinc_imm_addr", int'(bus.PER_ADDR), 0);
    chk("coinc_imm_data", int'(bus.PER_DATA), 8'h40);
    run_cycle();
    chk("coinc_slot0_silent", int'(bus.PER_WE), 0);

    // ---------------- stall during scan ----------------
    wait_tick();
    t = cyc;
    run_cycle();
    drive(1'b1, 1'b1, 6, 8'h5A);
    low = 0;
    while (bus.CMD_READY == 1'b0 && low < 3 * NCH) begin
      low++;
      run_cycle();
    end
    chk("stall_ready_low", low, NCH);
    chk("stall_accept_interval", cyc, t + NCH + 1);
    run_cycle();
    drive(1'b0, 1'b0, 0, 0);
    chk("stall_we", int'(bus.PER_WE), 1);
    chk("stall_addr", int'(bus.PER_ADDR), 6);
    chk("stall_data", int'(bus.PER_DATA), 8'h5A);

    // ---------------- reset mid-scan ----------------
    send(1'b0, 1, 8'h50);
    wait_tick();
    run_n(3);
    rst = 1'b1;
    #1;
    chk_outputs_zero("midscan_reset");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_cycle();
    chk("ready_after_release", int'(bus.CMD_READY), 1);
    run_cycle();
    seen.delete();
    run_n(3 * DIV);
    chk("no_we_after_reset", seen.size(), 0);

    // ---------------- directed command table ----------------
    for (int v = 0; v < 8; v++) begin
      send(vecs[v].imm, vecs[v].addr, vecs[v].data);
      chk("vec_we", int'(bus.PER_WE), int'(vecs[v].exp_we));
      if (vecs[v].exp_we) begin
        chk("vec_addr", int'(bus.PER_ADDR), vecs[v].exp_addr);
        chk("vec_data", int'(bus.PER_DATA), vecs[v].exp_data);
      end
    end

    // ---------------- random traffic against the model ----------------
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 3);
      drive($urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, NCH - 1),
            (r == 0) ? 0 : (r == 1) ? 255 : $urandom_range(0, 255));
      run_cycle();
    end
    drive(1'b0, 1'b0, 0, 0);
    run_n(3 * DIV);
    chk("model_queue_drained", wq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
